// File: rtl/bin2bcd_pkg.sv
// Shared types, constants and the leading-zero blanking helper for the
// sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

  localparam int unsigned DigitW    = 4;
  localparam int unsigned MaxDigits = 16;

  localparam logic [DigitW-1:0] AdjThresh = 4'd5;
  localparam logic [DigitW-1:0] AdjOffset = 4'd3;

  // Bit i (i >= 1) is set when every digit from the top down to i is zero.
  // The vector is sized for MaxDigits; callers zero-extend and slice.
  function automatic logic [MaxDigits-1:0] calc_blank_n(
    input logic [DigitW*MaxDigits-1:0] bcd,
    input int unsigned                 digits
  );
    logic [MaxDigits-1:0] blank;
    logic                 all_zero;
    blank    = '0;
    all_zero = 1'b1;
    for (int unsigned i = MaxDigits - 1; i >= 1; i--) begin
      if (i < digits) begin
        all_zero = all_zero && (bcd[i*DigitW +: DigitW] == '0);
        blank[i] = all_zero;
      end
    end
    return blank;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble per-digit correction: add 3 to a BCD digit of 5 or more.
module bcd_digit_adjust
  import bin2bcd_pkg::*;
(
  input  logic [DigitW-1:0] digit_i,
  output logic [DigitW-1:0] digit_o
);

  // Legal inputs never exceed 9, so the result fits in 4 bits (max 12).
  assign digit_o = (digit_i >= AdjThresh) ? digit_i + AdjOffset : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift/adjust step per clock behind a
// start/done handshake, with registered BCD output and leading-zero mask.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                     clock_100Mhz,
  input  logic                     reset,
  input  logic                     start,
  input  logic [BIN_W-1:0]         bin_in,
  output logic                     busy,
  output logic                     done,
  output logic [DigitW*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]        blank_n
);

  localparam int unsigned ScrW = DigitW * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W);

  localparam logic [MaxDigits-1:0] BlankRstFull = calc_blank_n('0, DIGITS);

  state_e              state_q, state_d;
  logic [BIN_W-1:0]    sh_q, sh_d;
  logic [ScrW-1:0]     scr_q, scr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [ScrW-1:0]     bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_q, blank_d;

  logic [ScrW-1:0]               scr_adj;
  logic [ScrW-1:0]               scr_shift;
  logic [DigitW*MaxDigits-1:0]   scr_ext;
  logic [MaxDigits-1:0]          blank_full;
  logic                          unused_bits;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i(scr_q[g*DigitW +: DigitW]),
      .digit_o(scr_adj[g*DigitW +: DigitW])
    );
  end

  // The top scratch bit shifted out is always zero for legal parameters.
  assign scr_shift   = {scr_adj[ScrW-2:0], sh_q[BIN_W-1]};
  assign unused_bits = ^{scr_adj[ScrW-1], blank_full};

  always_comb begin
    scr_ext            = '0;
    scr_ext[ScrW-1:0]  = scr_shift;
    blank_full         = calc_blank_n(scr_ext, DIGITS);
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    blank_d = blank_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sh_d    = bin_in;
          scr_d   = '0;
          cnt_d   = CntW'(BIN_W - 1);
          state_d = StShift;
        end
      end
      StShift: begin
        scr_d = scr_shift;
        sh_d  = {sh_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          bcd_d   = scr_shift;
          blank_d = blank_full[DIGITS-1:0];
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state_q <= StIdle;
      sh_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      blank_q <= BlankRstFull[DIGITS-1:0];
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
    end
  end

  assign busy    = (state_q == StShift);
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign blank_n = blank_q;

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential double-dabble binary-to-BCD converter feeding the seven-segment display multiplexer. Takes a binary count from the counter stage and produces packed BCD digits plus a leading-zero blank mask. The display mux then selects a digit per anode slot without hardware dividers. Each conversion runs one shift/adjust iteration per clock behind a start/done handshake, and the result is held stable between conversions.

## Interface
- `BIN_W`, default 16: binary input width; must be ≥ 4.
- `DIGITS`, default 5: BCD digits produced; must satisfy 10^DIGITS > 2^BIN_W − 1.
- `clock_100Mhz`, input, 1: system clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high; sampled on the rising edge of `clock_100Mhz`.
- `start`, input, 1: conversion request; accepted only in IDLE.
- `bin_in`, input, BIN_W: value to convert; sampled on the accepting edge only.
- `busy`, output, 1: high while a conversion is in progress.
- `done`, output, 1: one-cycle pulse when `bcd_out` updates.
- `bcd_out`, output, 4·DIGITS: packed BCD; digit 0 (units) is in bits [3:0].
- `blank_n`, output, DIGITS: bit i high means digit i is a leading zero. Bit 0 is always 0.

## Operation
- FSM states: IDLE and SHIFT.
- IDLE with `start`=1:
  - load shift register with `bin_in`
  - clear BCD scratch
  - set iteration counter to BIN_W−1
  - go to SHIFT
- IDLE with `start`=0: hold all state.
- SHIFT, each cycle:
  - add 3 to every scratch digit whose value is ≥ 5
  - shift {scratch, shift register} left by 1
  - decrement the counter
- SHIFT, final iteration (counter = 0):
  - load `bcd_out` with the post-shift scratch
  - recompute `blank_n` from the new value
  - pulse `done`
  - return to IDLE
- `start` while in SHIFT is ignored; it is not queued.
- Changes to `bin_in` after the accepting edge have no effect on the current conversion.
- `blank_n` rule: bit i (i ≥ 1) is 1 iff digits DIGITS−1 down to i are all zero.
- Arithmetic:
  - digit adjust is 4-bit with no carry out (the adjusted value is always ≤ 12)
  - scratch width is 4·DIGITS
  - bits shifted out of the top of the scratch are discarded; with legal parameters they are always 0

## Timing
- Reset (synchronous) forces:
  - state IDLE
  - `busy`=0, `done`=0
  - `bcd_out`=0
  - `blank_n` = all ones except bit 0 (DIGITS=5: 5'b11110)
  - scratch and counter cleared
- Latency: `start` sampled at edge E0; SHIFT iterations occur at edges E1..E_BIN_W.
  - `done`=1 and the new `bcd_out`/`blank_n` appear after edge E_BIN_W (17 edges for BIN_W=16).
- `busy`: 1 from after E0 through the cycle ending at E_BIN_W; it falls in the same cycle that `done` rises.
- `done` and `busy` are never high together.
- Back-to-back: the earliest next accepted `start` is at edge E_BIN_W+1. Throughput is one conversion per BIN_W+1 cycles.
- `bcd_out` and `blank_n` change only on a `done` edge or on reset; they never show intermediate values.
- Reset mid-conversion: the conversion is aborted, no `done` is generated, and outputs take their reset values.
- Reset and `start` in the same cycle: reset wins and `start` is dropped.

## Structure
- Package `bin2bcd_pkg`:
  - state enum (IDLE, SHIFT)
  - digit width constant 4
  - adjust threshold constant 5 and offset constant 3
  - function computing `blank_n` from a packed BCD vector
- Sub-module `bcd_digit_adjust`: combinational, 4-bit in and 4-bit out (value ≥ 5 ? value+3 : value). Instantiated DIGITS times in a generate loop.
- Top module: FSM, shift and scratch registers, counter, output registers.

## Test plan
- Reset, then `bin_in`=16'd1234 with `start` pulsed:
  - `done` is high exactly 17 cycles after the start edge
  - `bcd_out`=20'h01234, `blank_n`=5'b10000
  - `busy` is high for the 16 cycles before that
- `bin_in`=0: `bcd_out`=20'h00000, `blank_n`=5'b11110. `bin_in`=65535: `bcd_out`=20'h65535, `blank_n`=5'b00000.
- Back-to-back 9 then 10000, with the second `start` at the first edge after `done`:
  - first result: `bcd_out`=20'h00009, `blank_n`=5'b11110
  - second result: 20'h10000, `blank_n`=5'b00000, 17 cycles later
- `start` re-pulsed with `bin_in`=42 while `busy` during a conversion of 777:
  - only one `done`, with `bcd_out`=20'h00777
  - no extra `done`
- Reset asserted at iteration 8 of a 4321 conversion: no `done`, outputs at reset values. A following conversion of 4321 yields 20'h04321.
- Exhaustive sweep 0..65535 against a reference model:
  - every `bcd_out` and `blank_n` correct
  - every digit ≤ 9
  - outputs stable between `done` pulses
